// File: rtl/sqrt_mant_seq_if.sv
// Valid/ready handshake bundle between the unpack stage, the mantissa
// square-root sequencer and the rounding/pack stage.
interface sqrt_mant_seq_if #(
  parameter int unsigned ROOT_W = 24
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2*ROOT_W-1:0]   in_rad;
  logic                  out_valid;
  logic                  out_ready;
  logic [ROOT_W-1:0]     out_root;
  logic [ROOT_W:0]       out_rem;
  logic                  out_inexact;

  modport master (
    output in_valid,
    output in_rad,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_root,
    input  out_rem,
    input  out_inexact
  );

  modport slave (
    input  in_valid,
    input  in_rad,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_root,
    output out_rem,
    output out_inexact
  );
endinterface

// File: rtl/sqrt_mant_seq.sv
// Mantissa square-root sequencer: non-restoring digit recurrence, one root
// bit per clock, sharing a single ROOT_W+2-bit adder for iterate and fix-up.
module sqrt_mant_seq #(
  parameter int unsigned ROOT_W = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  sqrt_mant_seq_if.slave  bus,
  output logic            busy
);
  localparam int unsigned RW    = ROOT_W + 2;
  localparam int unsigned CNT_W = $clog2(ROOT_W);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t               state_q;
  logic [RW-1:0]        r_q;
  logic [ROOT_W-1:0]    q_q;
  logic [2*ROOT_W-1:0]  d_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 busy_q;
  logic [ROOT_W-1:0]    out_root_q;
  logic [ROOT_W:0]      out_rem_q;
  logic                 out_inexact_q;

  logic                 r_neg;
  logic [RW-1:0]        add_a;
  logic [RW-1:0]        add_b;
  logic                 add_cin;
  logic [RW-1:0]        add_sum;
  logic [RW-1:0]        fix_r;

  assign r_neg = r_q[RW-1];

  // D is shifted left two bits per iteration, so the current digit pair
  // P = D[2*count+1:2*count] is always found in the top two bits.
  always_comb begin
    add_a   = r_q;
    add_b   = {1'b0, q_q, 1'b1};
    add_cin = 1'b0;
    if (state_q == ITER) begin
      add_a = {r_q[RW-3:0], d_q[2*ROOT_W-1 -: 2]};
      if (!r_neg) begin
        add_b   = ~{q_q, 2'b01};
        add_cin = 1'b1;
      end else begin
        add_b   = {q_q, 2'b11};
      end
    end
    add_sum = add_a + add_b + RW'(add_cin);
    fix_r   = r_neg ? add_sum : r_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      r_q           <= '0;
      q_q           <= '0;
      d_q           <= '0;
      cnt_q         <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      out_root_q    <= '0;
      out_rem_q     <= '0;
      out_inexact_q <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            d_q        <= bus.in_rad;
            r_q        <= '0;
            q_q        <= '0;
            cnt_q      <= CNT_W'(ROOT_W - 1);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ITER;
          end
        end
        ITER: begin
          r_q   <= add_sum;
          q_q   <= {q_q[ROOT_W-2:0], ~add_sum[RW-1]};
          d_q   <= d_q << 2;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          r_q           <= fix_r;
          out_root_q    <= q_q;
          out_rem_q     <= fix_r[ROOT_W:0];
          out_inexact_q <= |fix_r;
          out_valid_q   <= 1'b1;
          busy_q        <= 1'b0;
          state_q       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_root    = out_root_q;
  assign bus.out_rem     = out_rem_q;
  assign bus.out_inexact = out_inexact_q;
  assign busy            = busy_q;
endmodule
